// File: rtl/audio_dac_serializer_if.sv
//==============================================================================
// Module      : audio_dac_serializer_if
// Description : Sample-pair handshake bundle feeding the DAC serializer.
//               master = sample producer (filter chain), slave = serializer.
// Signals     : left_channel_audio_in  [DATA_WIDTH] left sample
//               right_channel_audio_in [DATA_WIDTH] right sample
//               audio_in_valid         producer offers a pair
//               audio_in_ready         serializer holding buffer is empty
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

interface audio_dac_serializer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] left_channel_audio_in;
    logic [DATA_WIDTH-1:0] right_channel_audio_in;
    logic                  audio_in_valid;
    logic                  audio_in_ready;

    modport master (
        output left_channel_audio_in,
        output right_channel_audio_in,
        output audio_in_valid,
        input  audio_in_ready
    );

    modport slave (
        input  left_channel_audio_in,
        input  right_channel_audio_in,
        input  audio_in_valid,
        output audio_in_ready
    );
endinterface

`default_nettype wire

// File: rtl/audio_dac_serializer.sv
//==============================================================================
// Module      : audio_dac_serializer
// Description : I2S master-mode DAC serializer. Buffers one stereo pair,
//               generates AUD_DACLRCK from AUD_BCLK and shifts each word
//               MSB-first with the I2S one-bit delay. Flags buffer underruns.
// Ports       : AUD_BCLK       bit clock (only clock, rising edge)
//               reset          asynchronous active-high reset
//               enable         start / continue streaming frames
//               aud_in         sample-pair handshake (slave modport)
//               AUD_DACLRCK    word select, 0 = left slot, 1 = right / idle
//               AUD_DACDAT     serial data
//               underrun       one-cycle pulse at a starved frame start
//               underrun_count saturating count of underruns
// Config      : DAC_UNDERRUN_HOLD_EN - when defined, an underrun repeats the
//               last played pair; otherwise a zero pair is sent.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module audio_dac_serializer #(
    parameter int DATA_WIDTH       = 32,
    parameter int BCLK_PER_CHANNEL = 32
) (
    input  wire logic             AUD_BCLK,
    input  wire logic             reset,
    input  wire logic             enable,
    audio_dac_serializer_if.slave aud_in,
    output logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT,
    output logic                  underrun,
    output logic [15:0]           underrun_count
);

    localparam int CNT_W = (BCLK_PER_CHANNEL > 1) ? $clog2(BCLK_PER_CHANNEL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCLK_PER_CHANNEL - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic                    hold_full_q;
    logic [DATA_WIDTH-1:0]   hold_l_q;
    logic [DATA_WIDTH-1:0]   hold_r_q;
    logic [DATA_WIDTH-1:0]   shift_l_q;
    logic [DATA_WIDTH-1:0]   shift_r_q;
    logic                    lrck_q;
    logic                    dat_q;
    logic                    underrun_q;
    logic [15:0]             underrun_count_q;

    logic                    cnt_wrap;
    logic                    frame_start;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   fallback_l;
    logic [DATA_WIDTH-1:0]   fallback_r;

`ifdef DAC_UNDERRUN_HOLD_EN
    logic [DATA_WIDTH-1:0]   last_l_q;
    logic [DATA_WIDTH-1:0]   last_r_q;

    always_ff @(posedge AUD_BCLK or posedge reset) begin
        if (reset) begin
            last_l_q <= '0;
            last_r_q <= '0;
        end else if (frame_start && hold_full_q) begin
            last_l_q <= hold_l_q;
            last_r_q <= hold_r_q;
        end
    end

    assign fallback_l = last_l_q;
    assign fallback_r = last_r_q;
`else
    assign fallback_l = '0;
    assign fallback_r = '0;
`endif

    always_comb begin
        cnt_wrap    = (bit_cnt_q == CNT_LAST);
        frame_start = enable && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_RIGHT) && cnt_wrap));
        // Ready is low whenever the buffer is full, so accept and a
        // frame-start consumption can never coincide.
        accept      = aud_in.audio_in_valid && !hold_full_q;
    end

    always_ff @(posedge AUD_BCLK or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            bit_cnt_q        <= '0;
            hold_full_q      <= 1'b0;
            hold_l_q         <= '0;
            hold_r_q         <= '0;
            shift_l_q        <= '0;
            shift_r_q        <= '0;
            lrck_q           <= 1'b1;
            dat_q            <= 1'b0;
            underrun_q       <= 1'b0;
            underrun_count_q <= '0;
        end else begin
            underrun_q <= 1'b0;

            // The pin always lags the shifter by one cycle: the MSB goes out
            // in slot cycle 1 and, with a full-width slot, the LSB spills
            // into cycle 0 of the next slot (or the first IDLE cycle).
            // Zeros shift in behind the word so padding cycles drive 0.
            case (state_q)
                ST_LEFT: begin
                    dat_q     <= shift_l_q[DATA_WIDTH-1];
                    shift_l_q <= shift_l_q << 1;
                end
                ST_RIGHT: begin
                    dat_q     <= shift_r_q[DATA_WIDTH-1];
                    shift_r_q <= shift_r_q << 1;
                end
                default: dat_q <= 1'b0;
            endcase

            if (state_q != ST_IDLE) begin
                bit_cnt_q <= cnt_wrap ? '0 : bit_cnt_q + CNT_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q <= ST_LEFT;
                        lrck_q  <= 1'b0;
                    end
                end
                ST_LEFT: begin
                    if (cnt_wrap) begin
                        state_q <= ST_RIGHT;
                        lrck_q  <= 1'b1;
                    end
                end
                ST_RIGHT: begin
                    if (cnt_wrap) begin
                        state_q <= enable ? ST_LEFT : ST_IDLE;
                        lrck_q  <= !enable;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    lrck_q  <= 1'b1;
                end
            endcase

            // Loading overrides the shift above; the outgoing right LSB was
            // already taken into dat_q on this same edge.
            if (frame_start) begin
                if (hold_full_q) begin
                    shift_l_q   <= hold_l_q;
                    shift_r_q   <= hold_r_q;
                    hold_full_q <= 1'b0;
                end else begin
                    shift_l_q  <= fallback_l;
                    shift_r_q  <= fallback_r;
                    underrun_q <= 1'b1;
                    if (underrun_count_q != 16'hFFFF) begin
                        underrun_count_q <= underrun_count_q + 16'd1;
                    end
                end
            end

            if (accept) begin
                hold_l_q    <= aud_in.left_channel_audio_in;
                hold_r_q    <= aud_in.right_channel_audio_in;
                hold_full_q <= 1'b1;
            end
        end
    end

    assign aud_in.audio_in_ready = !hold_full_q;
    assign AUD_DACLRCK           = lrck_q;
    assign AUD_DACDAT            = dat_q;
    assign underrun              = underrun_q;
    assign underrun_count        = underrun_count_q;

endmodule

`default_nettype wire

// File: tb/tb_audio_dac_serializer.sv
//==============================================================================
// Module      : tb_audio_dac_serializer
// Description : Self-checking bench for audio_dac_serializer. A frame-level
//               reference model predicts every output each cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_audio_dac_serializer;

    localparam int DW = 32;
    localparam int B  = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        lrck;
    logic        dat;
    logic        urun;
    logic [15:0] ucnt;

    always #5 clk = ~clk;

    audio_dac_serializer_if #(.DATA_WIDTH(DW)) bus ();

    audio_dac_serializer #(
        .DATA_WIDTH       (DW),
        .BCLK_PER_CHANNEL (B)
    ) dut (
        .AUD_BCLK       (clk),
        .reset          (rst),
        .enable         (enable),
        .aud_in         (bus),
        .AUD_DACLRCK    (lrck),
        .AUD_DACDAT     (dat),
        .underrun       (urun),
        .underrun_count (ucnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    logic [DW-1:0] q_l[$];
    logic [DW-1:0] q_r[$];
    logic [DW-1:0] last_l, last_r, cur_l, cur_r, prv_l, prv_r;
    longint        n, fs, prv_fs;
    bit            running, m_urun, m_acc;
    logic [15:0]   m_cnt;

    function automatic void model_reset();
        q_l.delete();
        q_r.delete();
        last_l = '0; last_r = '0;
        cur_l = '0; cur_r = '0; prv_l = '0; prv_r = '0;
        n = 0; fs = -1000; prv_fs = -1000;
        running = 0; m_urun = 0; m_acc = 0; m_cnt = '0;
    endfunction

    // Called once per rising edge with the inputs the DUT sampled there.
    function automatic void model_edge();
        bit rdy    = (q_l.size() == 0);
        bit fstart = 0;
        n++;
        m_urun = 0;
        m_acc  = 0;
        if (!running) begin
            if (enable) fstart = 1;
        end else if (n == fs + 2 * B) begin
            if (enable) fstart = 1;
            else running = 0;
        end
        if (fstart) begin
            running = 1;
            prv_l = cur_l; prv_r = cur_r; prv_fs = fs;
            fs = n;
            if (q_l.size() != 0) begin
                cur_l = q_l.pop_front();
                cur_r = q_r.pop_front();
                last_l = cur_l; last_r = cur_r;
            end else begin
                m_urun = 1;
                if (m_cnt != 16'hFFFF) m_cnt++;
`ifdef DAC_UNDERRUN_HOLD_EN
                cur_l = last_l; cur_r = last_r;
`else
                cur_l = '0; cur_r = '0;
`endif
            end
        end
        if (bus.audio_in_valid && rdy) begin
            q_l.push_back(bus.left_channel_audio_in);
            q_r.push_back(bus.right_channel_audio_in);
            m_acc = 1;
        end
    endfunction

    // Bit a frame puts on the pin o cycles after its frame start.
    function automatic logic slot_bit(longint o, logic [DW-1:0] l, logic [DW-1:0] r);
        if (o >= 1 && o <= DW) return l[DW - int'(o)];
        if (o >= B + 1 && o <= B + DW) return r[B + DW - int'(o)];
        return 1'b0;
    endfunction

    task automatic step();
        logic e_lrck, e_dat;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        e_lrck = !(running && (n - fs) < B);
        e_dat  = slot_bit(n - fs, cur_l, cur_r) | slot_bit(n - prv_fs, prv_l, prv_r);
        check("lrck",  32'(lrck), 32'(e_lrck));
        check("dat",   32'(dat),  32'(e_dat));
        check("ready", 32'(bus.audio_in_ready), 32'(q_l.size() == 0));
        check("urun",  32'(urun), 32'(m_urun));
        check("ucnt",  32'(ucnt), 32'(m_cnt));
    endtask

    task automatic new_pair();
        bus.left_channel_audio_in  = $urandom;
        bus.right_channel_audio_in = $urandom;
    endtask

    // mode 0: one-shot, 1: continuous, 2: random gaps, 3: starve
    task automatic run(input int cycles, input int mode);
        for (int i = 0; i < cycles; i++) begin
            step();
            case (mode)
                0: if (m_acc) bus.audio_in_valid = 1'b0;
                1: begin
                    if (m_acc) new_pair();
                    bus.audio_in_valid = 1'b1;
                end
                2: begin
                    if (m_acc) new_pair();
                    if (m_acc || !bus.audio_in_valid)
                        bus.audio_in_valid = ($urandom_range(0, 2) == 0);
                end
                default: bus.audio_in_valid = 1'b0;
            endcase
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_lrck",  32'(lrck), 32'd1);
        check("rst_dat",   32'(dat),  32'd0);
        check("rst_ready", 32'(bus.audio_in_ready), 32'd1);
        check("rst_urun",  32'(urun), 32'd0);
        check("rst_ucnt",  32'(ucnt), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int k;
        rst    = 1'b1;
        enable = 1'b0;
        bus.audio_in_valid         = 1'b0;
        bus.left_channel_audio_in  = '0;
        bus.right_channel_audio_in = '0;
        @(negedge clk);
        do_reset();

        // Directed pair offered from reset release: first frame underruns,
        // the pair plays in the second frame.
        rst = 1'b1;
        @(negedge clk);
        bus.left_channel_audio_in  = 32'h8000_0001;
        bus.right_channel_audio_in = 32'h7FFF_FFFE;
        bus.audio_in_valid         = 1'b1;
        enable                     = 1'b1;
        model_reset();
        rst = 1'b0;
        run(3 * 2 * B, 0);

        // Continuous stream, random gaps, then starvation.
        new_pair();
        run(6 * 2 * B, 1);
        run(6 * 2 * B, 2);
        run(3 * 2 * B + 4, 3);
        run(2 * 2 * B, 1);

        // Drop enable at cycle 10 of a left slot.
        k = 0;
        while (!(running && (n - fs) == 9) && k < 300) begin
            run(1, 1);
            k++;
        end
        check("wait_left10", 32'(k < 300), 32'd1);
        enable = 1'b0;
        run(3 * B + 20, 1);
        enable = 1'b1;
        run(3 * 2 * B, 2);
        run(2 * 2 * B, 3);

        // Reset at cycle 20 of a right slot with the buffer full.
        k = 0;
        while (!(running && (n - fs) == B + 20 && q_l.size() != 0) && k < 500) begin
            run(1, 1);
            k++;
        end
        check("wait_right20", 32'(k < 500), 32'd1);
        check("pre_rst_cnt_nonzero", 32'(m_cnt != 0), 32'd1);
        do_reset();
        run(3 * 2 * B, 2);

        // Saturation: preload the counter, then keep starving.
        force dut.underrun_count_q = 16'hFFFE;
        #1;
        release dut.underrun_count_q;
        m_cnt = 16'hFFFE;
        check("ucnt_preload", 32'(ucnt), 32'(m_cnt));
        run(4 * 2 * B, 3);
        check("ucnt_sat", 32'(ucnt), 32'h0000_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
